// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with iterative single-bit shifts and zero/carry/neg flags.
// Optional build macro ALU_SAT_EN: inc/dec/sub saturate instead of wrapping (carry still set).
module alu_seq #(
  parameter int unsigned W = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   ALU_Op,
  input  logic [2:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] rslt,
  output logic         zero,
  output logic         carry,
  output logic         neg
);

  localparam int unsigned CW = $clog2(W) + 1;
  localparam logic [W-1:0] WMax = W'(W);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e        r_state, w_state_d;
  logic [W-1:0]  r_rslt, w_rslt_d;
  logic          r_carry, w_carry_d;
  logic [CW-1:0] r_cnt, w_cnt_d;
  logic          r_shl, w_shl_d;

  logic [CW-1:0] w_n;
  logic [W:0]    w_inc, w_dec, w_sub;

  // Shift amounts at or beyond W all clear the word; clamp so the counter stays small.
  assign w_n   = (inB >= WMax) ? CW'(W) : inB[CW-1:0];
  // Extra MSB carries the carry-out (inc) or borrow (dec/sub).
  assign w_inc = {1'b0, inA} + {{W{1'b0}}, 1'b1};
  assign w_dec = {1'b0, inA} - {{W{1'b0}}, 1'b1};
  assign w_sub = {1'b0, inA} - {1'b0, inB};

  // Next-state, result and flag computation.
  always_comb begin
    w_state_d = r_state;
    w_rslt_d  = r_rslt;
    w_carry_d = r_carry;
    w_cnt_d   = r_cnt;
    w_shl_d   = r_shl;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_carry_d = 1'b0;
          w_state_d = StDone;
          unique case (ALU_Op)
            2'b00: begin
              unique case (alu_cmd)
                3'b000: w_rslt_d = inB;
                3'b001, 3'b010: begin
                  w_rslt_d = inA;
                  w_cnt_d  = w_n;
                  w_shl_d  = (alu_cmd == 3'b001);
                  if (w_n != '0) w_state_d = StShift;
                end
                3'b011: w_rslt_d = inA & inB;
                3'b100: w_rslt_d = inA | inB;
                3'b101: w_rslt_d = inA ^ inB;
                3'b110: w_rslt_d = '0;
                default: w_rslt_d = {{(W-1){1'b0}}, ^inB};
              endcase
            end
            2'b01: begin
              w_carry_d = w_dec[W];
`ifdef ALU_SAT_EN
              w_rslt_d  = w_dec[W] ? '0 : w_dec[W-1:0];
`else
              w_rslt_d  = w_dec[W-1:0];
`endif
            end
            2'b10: begin
              w_carry_d = w_inc[W];
`ifdef ALU_SAT_EN
              w_rslt_d  = w_inc[W] ? '1 : w_inc[W-1:0];
`else
              w_rslt_d  = w_inc[W-1:0];
`endif
            end
            default: begin
              w_carry_d = w_sub[W];
`ifdef ALU_SAT_EN
              w_rslt_d  = w_sub[W] ? '0 : w_sub[W-1:0];
`else
              w_rslt_d  = w_sub[W-1:0];
`endif
            end
          endcase
        end
      end
      StShift: begin
        // One bit per cycle; carry captures the bit that falls off the end.
        if (r_shl) begin
          {w_carry_d, w_rslt_d} = {r_rslt, 1'b0};
        end else begin
          {w_rslt_d, w_carry_d} = {1'b0, r_rslt};
        end
        w_cnt_d = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_d = StDone;
      end
      StDone: begin
        if (out_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= StIdle;
      r_rslt  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_shl   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_rslt  <= w_rslt_d;
      r_carry <= w_carry_d;
      r_cnt   <= w_cnt_d;
      r_shl   <= w_shl_d;
    end
  end

  assign in_ready  = (r_state == StIdle) && Reset_n;
  assign out_valid = (r_state == StDone);
  assign rslt      = r_rslt;
  assign carry     = r_carry;
  assign zero      = (r_rslt == '0);
  assign neg       = r_rslt[W-1];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural model plus directed vectors with literal results.
module tb_alu_seq;

  localparam int W = 8;
`ifdef ALU_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic         Clk, Reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   ALU_Op;
  logic [2:0]   alu_cmd;
  logic [W-1:0] inA, inB, rslt;
  logic         zero, carry, neg;

  alu_seq #(.W(W)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALU_Op   (ALU_Op),
    .alu_cmd  (alu_cmd),
    .inA      (inA),
    .inB      (inB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rslt     (rslt),
    .zero     (zero),
    .carry    (carry),
    .neg      (neg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    int           lat;
  } exp_t;

  function automatic exp_t model_op(input logic [1:0] op, input logic [2:0] cmd,
                                    input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int av, bv, mx, n;
    av = int'(a);
    bv = int'(b);
    mx = (1 << W) - 1;
    e.r = '0;
    e.c = 1'b0;
    e.lat = 1;
    case (op)
      2'd1: if (av == 0) begin e.c = 1'b1; e.r = Sat ? '0 : W'(mx); end else e.r = W'(av - 1);
      2'd2: if (av == mx) begin e.c = 1'b1; e.r = Sat ? W'(mx) : '0; end else e.r = W'(av + 1);
      2'd3: if (av < bv) begin
              e.c = 1'b1;
              e.r = Sat ? '0 : W'(av - bv + mx + 1);
            end else e.r = W'(av - bv);
      default: begin
        n = (bv > W) ? W : bv;
        case (cmd)
          3'd0: e.r = b;
          3'd1: begin
            e.r = W'(av << n);
            e.c = (n == 0) ? 1'b0 : a[W-n];
            e.lat = n + 1;
          end
          3'd2: begin
            e.r = W'(av >> n);
            e.c = (n == 0) ? 1'b0 : a[n-1];
            e.lat = n + 1;
          end
          3'd3: e.r = a & b;
          3'd4: e.r = a | b;
          3'd5: e.r = a ^ b;
          3'd6: e.r = '0;
          default: e.r = W'($countones(b) % 2);
        endcase
      end
    endcase
    return e;
  endfunction

  typedef enum int {PIdle, PBusy, PDone} phase_e;
  phase_e       m_phase;
  logic         m_init = 1'b0;
  logic [W-1:0] m_rslt, m_pr;
  logic         m_carry, m_pc;
  int           m_wait;
  exp_t         m_exp;

  always_comb m_exp = model_op(ALU_Op, alu_cmd, inA, inB);

  // Model advances on the same edge as the DUT.
  always @(posedge Clk) begin
    if (!Reset_n) begin
      m_phase <= PIdle;
      m_rslt  <= '0;
      m_carry <= 1'b0;
      m_init  <= 1'b1;
    end else if (m_init) begin
      case (m_phase)
        PIdle: if (in_valid) begin
          if (m_exp.lat == 1) begin
            m_phase <= PDone;
            m_rslt  <= m_exp.r;
            m_carry <= m_exp.c;
          end else begin
            m_phase <= PBusy;
            m_wait  <= m_exp.lat - 1;
            m_pr    <= m_exp.r;
            m_pc    <= m_exp.c;
          end
        end
        PBusy: if (m_wait == 1) begin
          m_phase <= PDone;
          m_rslt  <= m_pr;
          m_carry <= m_pc;
        end else m_wait <= m_wait - 1;
        default: if (out_ready) m_phase <= PIdle;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (m_init) begin
      chk("cmp_in_ready", in_ready, (m_phase == PIdle) && Reset_n);
      chk("cmp_out_valid", out_valid, m_phase == PDone);
      if (m_phase != PBusy) begin
        chk("cmp_rslt", rslt, m_rslt);
        chk("cmp_carry", carry, m_carry);
        chk("cmp_zero", zero, m_rslt == '0);
        chk("cmp_neg", neg, m_rslt[W-1]);
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0] op;
    logic [2:0] cmd;
    logic [7:0] a, b, r;
    logic       c;
    int         lat;
    int         hold;
  } vec_t;

  localparam logic [7:0] IncFF = Sat ? 8'hFF : 8'h00;
  localparam logic [7:0] Dec00 = Sat ? 8'h00 : 8'hFF;
  localparam logic [7:0] Sub57 = Sat ? 8'h00 : 8'hFE;

  vec_t vecs[17] = '{
    '{2'b00, 3'b101, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1, 0},  // xor
    '{2'b00, 3'b001, 8'h81, 8'h03, 8'h08, 1'b0, 4, 0},  // shl 3
    '{2'b00, 3'b010, 8'h81, 8'h09, 8'h00, 1'b1, 9, 0},  // shr 9 -> clamps to 8
    '{2'b11, 3'b000, 8'h05, 8'h07, Sub57, 1'b1, 1, 5},  // sub borrow, backpressure
    '{2'b10, 3'b000, 8'hFF, 8'h00, IncFF, 1'b1, 1, 0},  // inc overflow
    '{2'b01, 3'b000, 8'h00, 8'h00, Dec00, 1'b1, 1, 2},  // dec underflow
    '{2'b00, 3'b000, 8'h12, 8'hA5, 8'hA5, 1'b0, 1, 0},  // pass B
    '{2'b00, 3'b011, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1, 0},  // and
    '{2'b00, 3'b100, 8'h30, 8'h05, 8'h35, 1'b0, 1, 0},  // or
    '{2'b00, 3'b110, 8'hFF, 8'hFF, 8'h00, 1'b0, 1, 0},  // zero
    '{2'b00, 3'b111, 8'hAA, 8'h07, 8'h01, 1'b0, 1, 0},  // parity
    '{2'b00, 3'b001, 8'h5A, 8'h00, 8'h5A, 1'b0, 1, 0},  // shl by 0
    '{2'b00, 3'b010, 8'hB4, 8'h03, 8'h16, 1'b1, 4, 3},  // shr 3
    '{2'b11, 3'b000, 8'h09, 8'h04, 8'h05, 1'b0, 1, 0},  // sub no borrow
    '{2'b10, 3'b000, 8'h7F, 8'h00, 8'h80, 1'b0, 1, 0},  // inc to negative
    '{2'b00, 3'b001, 8'h81, 8'h08, 8'h00, 1'b1, 9, 0},  // shl by W
    '{2'b00, 3'b001, 8'h01, 8'hFF, 8'h00, 1'b1, 9, 0}   // shl by 255
  };

  task automatic run_op(input vec_t v);
    int lat, guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    chk("wait_in_ready", in_ready, 1'b1);
    in_valid  = 1'b1;
    ALU_Op    = v.op;
    alu_cmd   = v.cmd;
    inA       = v.a;
    inB       = v.b;
    out_ready = (v.hold == 0);
    @(negedge Clk);
    in_valid = 1'b0;
    ALU_Op   = 2'($urandom);
    alu_cmd  = 3'($urandom);
    inA      = W'($urandom);
    inB      = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge Clk);
      lat++;
    end
    chk("vec_latency", lat, v.lat);
    chk("vec_rslt", rslt, v.r);
    chk("vec_carry", carry, v.c);
    chk("vec_zero", zero, v.r == 8'h00);
    chk("vec_neg", neg, v.r[7]);
    if (v.hold > 0) begin
      repeat (v.hold) @(negedge Clk);
      chk("vec_held_rslt", rslt, v.r);
      chk("vec_held_valid", out_valid, 1'b1);
      out_ready = 1'b1;
    end
    @(negedge Clk);
    chk("vec_back_idle", in_ready, 1'b1);
  endtask

  initial begin
    Reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ALU_Op    = '0;
    alu_cmd   = '0;
    inA       = '0;
    inB       = '0;
    repeat (2) @(negedge Clk);
    chk("rst_rslt", rslt, 8'h00);
    chk("rst_zero", zero, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("post_rst_in_ready", in_ready, 1'b1);

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset during the second shift cycle of a shift-left by 5 abandons the operation.
    in_valid = 1'b1;
    ALU_Op   = 2'b00;
    alu_cmd  = 3'b001;
    inA      = 8'hFF;
    inB      = 8'h05;
    @(negedge Clk);
    in_valid = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("midrst_rslt", rslt, 8'h00);
    chk("midrst_out_valid", out_valid, 1'b0);
    Reset_n = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      chk("midrst_no_result", out_valid, 1'b0);
    end
    run_op('{2'b00, 3'b011, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1, 0});

    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
